// File: rtl/uart_tx_sb_ctrl.sv
// Memory-mapped UART transmitter (decoder request bit 5, read-mux select 6).
// Optional build macro UART_TX_FIFO_EN adds a 4-entry byte FIFO ahead of the shifter.
module uart_tx_sb_ctrl #(
  parameter logic [15:0] DIV_DEFAULT  = 16'd1042,
  parameter logic [1:0]  STOP_DEFAULT = 2'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o
);

  localparam logic [11:0] OFF_DATA  = 12'h000;
  localparam logic [11:0] OFF_BUSY  = 12'h004;
  localparam logic [11:0] OFF_DIV   = 12'h008;
  localparam logic [11:0] OFF_PAR   = 12'h00C;
  localparam logic [11:0] OFF_STOP  = 12'h010;
  localparam logic [11:0] OFF_COUNT = 12'h014;
  localparam logic [11:0] OFF_SRST  = 12'h024;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] divider_q, divider_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        parity_en_q, parity_en_d;
  logic [1:0]  stop_bits_q, stop_bits_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_bit_q, parity_bit_d;
  logic        frame_par_q, frame_par_d;
  logic        frame_two_stop_q, frame_two_stop_d;
  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic [31:0] read_data_q, read_data_d;

  logic [11:0] offset;
  logic        wr_acc, rd_acc, soft_rst, cfg_lock, load, baud_last;
  logic [7:0]  load_byte;
  logic [2:0]  fifo_count_rd;
  logic        unused_addr;

  assign offset      = addr_i[11:0];
  assign unused_addr = ^addr_i[31:12];
  assign wr_acc      = req_i & write_enable_i;
  assign rd_acc      = req_i & ~write_enable_i;
  assign soft_rst    = wr_acc && (offset == OFF_SRST) && write_data_i[0];
  assign baud_last   = (baud_cnt_q == (divider_q - 16'd1));

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_mem_q [4];
  logic [7:0] fifo_mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] fifo_count_q, fifo_count_d;
  logic       push;

  // The shifter is fed from the FIFO head; a push never bypasses straight into the shifter.
  assign push          = wr_acc && (offset == OFF_DATA) && (fifo_count_q != 3'd4);
  assign load          = (state_q == IDLE) && (fifo_count_q != 3'd0);
  assign load_byte     = fifo_mem_q[rd_ptr_q];
  assign cfg_lock      = (state_q != IDLE) || (fifo_count_q != 3'd0);
  assign fifo_count_rd = fifo_count_q;
`else
  assign load          = wr_acc && (offset == OFF_DATA) && (state_q == IDLE);
  assign load_byte     = write_data_i[7:0];
  assign cfg_lock      = (state_q != IDLE);
  assign fifo_count_rd = 3'd0;
`endif

  always_comb begin
    state_d          = state_q;
    divider_d        = divider_q;
    baud_cnt_d       = baud_cnt_q;
    parity_en_d      = parity_en_q;
    stop_bits_d      = stop_bits_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    parity_bit_d     = parity_bit_q;
    frame_par_d      = frame_par_q;
    frame_two_stop_d = frame_two_stop_q;
    tx_d             = tx_q;
    read_data_d      = read_data_q;

    if (rd_acc) begin
      case (offset)
        OFF_BUSY:  read_data_d = {31'd0, busy_q};
        OFF_DIV:   read_data_d = {16'd0, divider_q};
        OFF_PAR:   read_data_d = {31'd0, parity_en_q};
        OFF_STOP:  read_data_d = {30'd0, stop_bits_q};
        OFF_COUNT: read_data_d = {29'd0, fifo_count_rd};
        default:   read_data_d = 32'd0;
      endcase
    end

    if (wr_acc && !cfg_lock) begin
      case (offset)
        OFF_DIV: if (write_data_i[15:0] >= 16'd2) divider_d = write_data_i[15:0];
        OFF_PAR: parity_en_d = write_data_i[0];
        OFF_STOP: begin
          if ((write_data_i == 32'd1) || (write_data_i == 32'd2)) stop_bits_d = write_data_i[1:0];
        end
        default: ;
      endcase
    end

    // Parity and stop count are captured with the byte so the frame is self-contained.
    if (state_q == IDLE) begin
      if (load) begin
        state_d          = START;
        baud_cnt_d       = 16'd0;
        bit_cnt_d        = 3'd0;
        shift_d          = load_byte;
        parity_bit_d     = ^load_byte;
        frame_par_d      = parity_en_q;
        frame_two_stop_d = (stop_bits_q == 2'd2);
        tx_d             = 1'b0;
      end
    end else if (!baud_last) begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end else begin
      baud_cnt_d = 16'd0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
        DATA: begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (frame_par_q) begin
              state_d = PARITY;
              tx_d    = parity_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
        PARITY: begin
          state_d   = STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end
        STOP: begin
          if (!frame_two_stop_q || (bit_cnt_q == 3'd1)) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

`ifdef UART_TX_FIFO_EN
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = write_data_i[7:0];
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (load) rd_ptr_d = rd_ptr_q + 2'd1;
    fifo_count_d = fifo_count_q + {2'd0, push} - {2'd0, load};
    busy_d       = (fifo_count_d == 3'd4);
`else
    busy_d = (state_d != IDLE);
`endif

    if (soft_rst) begin
      state_d          = IDLE;
      divider_d        = DIV_DEFAULT;
      baud_cnt_d       = 16'd0;
      parity_en_d      = 1'b0;
      stop_bits_d      = STOP_DEFAULT;
      bit_cnt_d        = 3'd0;
      shift_d          = 8'd0;
      parity_bit_d     = 1'b0;
      frame_par_d      = 1'b0;
      frame_two_stop_d = 1'b0;
      tx_d             = 1'b1;
      read_data_d      = 32'd0;
      busy_d           = 1'b0;
`ifdef UART_TX_FIFO_EN
      wr_ptr_d     = 2'd0;
      rd_ptr_d     = 2'd0;
      fifo_count_d = 3'd0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      divider_q        <= DIV_DEFAULT;
      baud_cnt_q       <= 16'd0;
      parity_en_q      <= 1'b0;
      stop_bits_q      <= STOP_DEFAULT;
      bit_cnt_q        <= 3'd0;
      shift_q          <= 8'd0;
      parity_bit_q     <= 1'b0;
      frame_par_q      <= 1'b0;
      frame_two_stop_q <= 1'b0;
      busy_q           <= 1'b0;
      tx_q             <= 1'b1;
      read_data_q      <= 32'd0;
`ifdef UART_TX_FIFO_EN
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 8'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      fifo_count_q <= 3'd0;
`endif
    end else begin
      state_q          <= state_d;
      divider_q        <= divider_d;
      baud_cnt_q       <= baud_cnt_d;
      parity_en_q      <= parity_en_d;
      stop_bits_q      <= stop_bits_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      parity_bit_q     <= parity_bit_d;
      frame_par_q      <= frame_par_d;
      frame_two_stop_q <= frame_two_stop_d;
      busy_q           <= busy_d;
      tx_q             <= tx_d;
      read_data_q      <= read_data_d;
`ifdef UART_TX_FIFO_EN
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= fifo_mem_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
`endif
    end
  end

  assign read_data_o = read_data_q;
  assign tx_o        = tx_q;

endmodule
